// File: rtl/iob_sub_seq.sv
`default_nettype none
// ============================================================================
// iob_sub_seq : sequential N-operand subtractor, one subtrahend per cycle,
//               valid/ready on both sides, exact sticky borrow.
// Revision    : 1.0
// ============================================================================
module iob_sub_seq #(
  parameter int W = 21,
  parameter int N = 21
) (
  input  logic           clk_i,
  input  logic           arst_n_i,
  input  logic           cke_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [N*W-1:0] in_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [W-1:0]   diff_o,
  output logic           borrow_o
);
  localparam int            KW     = ($clog2(N) < 1) ? 1 : $clog2(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  op_q [N];
  logic [W-1:0]  op_d [N];
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  diff_q, diff_d;
  logic          brw_q, brw_d;
  logic          bout_q, bout_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  sub_w;
  logic          step_brw_w;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= S_IDLE;
    end else if (cke_i) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid_i) state_d = S_RUN;
      S_RUN:   if (k_q == K_LAST) state_d = S_DONE;
      S_DONE:  if (out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == S_IDLE);
    out_valid_o = (state_q == S_DONE);
    diff_o      = diff_q;
    borrow_o    = bout_q;
  end

  assign sub_w      = op_q[k_q];
  assign step_brw_w = (acc_q < sub_w);

  // The result registers are written only on the final step, so diff_o and
  // borrow_o never show intermediate accumulator values.
  always_comb begin
    op_d   = op_q;
    acc_d  = acc_q;
    brw_d  = brw_q;
    k_d    = k_q;
    diff_d = diff_q;
    bout_d = bout_q;
    if (state_q == S_IDLE && in_valid_i) begin
      for (int j = 0; j < N; j++) begin
        op_d[j] = in_i[j*W +: W];
      end
      acc_d = in_i[W-1:0];
      brw_d = 1'b0;
      k_d   = KW'(1);
    end else if (state_q == S_RUN) begin
      acc_d = acc_q - sub_w;
      brw_d = brw_q | step_brw_w;
      k_d   = k_q + KW'(1);
      if (k_q == K_LAST) begin
        diff_d = acc_q - sub_w;
        bout_d = brw_q | step_brw_w;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int j = 0; j < N; j++) begin
        op_q[j] <= '0;
      end
      acc_q  <= '0;
      brw_q  <= 1'b0;
      k_q    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (cke_i) begin
      op_q   <= op_d;
      acc_q  <= acc_d;
      brw_q  <= brw_d;
      k_q    <= k_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iob_sub_seq.sv
`default_nettype none
// ============================================================================
// tb_iob_sub_seq : directed bench for three configurations of iob_sub_seq
//                  (W8/N4, W8/N2, W21/N21) against an arithmetic model.
// Revision       : 1.0
// ============================================================================
module tb_iob_sub_seq;
  logic         clk;
  logic         arst_n;
  logic         cke  [3];
  logic         vld  [3];
  logic         ordy [3];
  logic [440:0] in_v [3];

  logic         rdy0, rdy1, rdy2, ov0, ov1, ov2, b0, b1, b2;
  logic [7:0]   d0, d1;
  logic [20:0]  d2;

  logic         rdy_a [3];
  logic         ov_a  [3];
  logic         brw_a [3];
  logic [20:0]  dif_a [3];

  int tot;
  int bad;
  bit chk_on;

  // Behavioural model: state 0 idle, 1 computing, 2 result held
  int     m_st  [3];
  int     m_cnt [3];
  longint m_pd  [3];
  bit     m_pb  [3];
  longint m_d   [3];
  bit     m_b   [3];

  iob_sub_seq #(.W(8), .N(4)) u0 (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke[0]), .in_valid_i(vld[0]),
    .in_ready_o(rdy0), .in_i(in_v[0][31:0]), .out_valid_o(ov0),
    .out_ready_i(ordy[0]), .diff_o(d0), .borrow_o(b0));

  iob_sub_seq #(.W(8), .N(2)) u1 (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke[1]), .in_valid_i(vld[1]),
    .in_ready_o(rdy1), .in_i(in_v[1][15:0]), .out_valid_o(ov1),
    .out_ready_i(ordy[1]), .diff_o(d1), .borrow_o(b1));

  iob_sub_seq u2 (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke[2]), .in_valid_i(vld[2]),
    .in_ready_o(rdy2), .in_i(in_v[2]), .out_valid_o(ov2),
    .out_ready_i(ordy[2]), .diff_o(d2), .borrow_o(b2));

  always_comb begin
    rdy_a[0] = rdy0; rdy_a[1] = rdy1; rdy_a[2] = rdy2;
    ov_a[0]  = ov0;  ov_a[1]  = ov1;  ov_a[2]  = ov2;
    brw_a[0] = b0;   brw_a[1] = b1;   brw_a[2] = b2;
    dif_a[0] = 21'(d0);
    dif_a[1] = 21'(d1);
    dif_a[2] = d2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nw(input int i);
    return (i == 0) ? 4 : (i == 1) ? 2 : 21;
  endfunction

  function automatic int ww(input int i);
    return (i == 2) ? 21 : 8;
  endfunction

  function automatic longint opnd(input int i, input logic [440:0] v, input int k);
    logic [440:0] t;
    longint       mask;
    mask = (64'sd1 <<< ww(i)) - 1;
    t    = v >> (k * ww(i));
    return longint'(t[63:0]) & mask;
  endfunction

  function automatic longint subtrahend_sum(input int i, input logic [440:0] v);
    longint s;
    s = 0;
    for (int k = 1; k < nw(i); k++) s += opnd(i, v, k);
    return s;
  endfunction

  function automatic longint cdiff(input int i, input logic [440:0] v);
    longint mask;
    mask = (64'sd1 <<< ww(i)) - 1;
    return (opnd(i, v, 0) - subtrahend_sum(i, v)) & mask;
  endfunction

  function automatic bit cbrw(input int i, input logic [440:0] v);
    return opnd(i, v, 0) < subtrahend_sum(i, v);
  endfunction

  always @(posedge clk or negedge arst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!arst_n) begin
        m_st[i]  <= 0;
        m_cnt[i] <= 0;
        m_pd[i]  <= 0;
        m_pb[i]  <= 1'b0;
        m_d[i]   <= 0;
        m_b[i]   <= 1'b0;
      end else if (cke[i]) begin
        case (m_st[i])
          0: if (vld[i]) begin
            m_st[i]  <= 1;
            m_cnt[i] <= nw(i) - 1;
            m_pd[i]  <= cdiff(i, in_v[i]);
            m_pb[i]  <= cbrw(i, in_v[i]);
          end
          1: begin
            m_cnt[i] <= m_cnt[i] - 1;
            if (m_cnt[i] == 1) begin
              m_st[i] <= 2;
              m_d[i]  <= m_pd[i];
              m_b[i]  <= m_pb[i];
            end
          end
          default: if (ordy[i]) m_st[i] <= 0;
        endcase
      end
    end
  end

  task automatic chk(input string name, input int i, input longint act, input longint exp);
    tot++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s inst%0d: got=%0d want=%0d at %0t", name, i, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        chk("in_ready", i, longint'(rdy_a[i]), longint'(m_st[i] == 0));
        chk("out_valid", i, longint'(ov_a[i]), longint'(m_st[i] == 2));
        chk("diff", i, longint'(dif_a[i]), m_d[i]);
        chk("borrow", i, longint'(brw_a[i]), longint'(m_b[i]));
      end
    end
  end

  task automatic load(input int i, input longint ops[21]);
    logic [440:0] v;
    longint       mask;
    mask = (64'sd1 <<< ww(i)) - 1;
    v    = '0;
    for (int k = 0; k < nw(i); k++) v |= 441'(ops[k] & mask) << (k * ww(i));
    in_v[i] = v;
  endtask

  // Returns at the first falling edge after the accepting edge
  task automatic start(input int i, input longint ops[21]);
    int g;
    load(i, ops);
    vld[i] = 1'b1;
    g = 0;
    while (!(rdy_a[i] && cke[i]) && g <= 50) begin
      @(negedge clk);
      g++;
    end
    if (g > 50) chk("accept_timeout", i, 0, 1);
    @(negedge clk);
    vld[i]  = 1'b0;
    in_v[i] = ~in_v[i];
  endtask

  task automatic wait_done(input int i, input int gs, input int gl, output int lat);
    int c;
    c = 0;
    while (!ov_a[i] && c <= 200) begin
      @(negedge clk);
      c++;
      if (c == gs) cke[i] = 1'b0;
      if (c == gs + gl) cke[i] = 1'b1;
    end
    if (c > 200) chk("done_timeout", i, 0, 1);
    lat = c;
  endtask

  task automatic consume(input int i);
    ordy[i] = 1'b1;
    @(negedge clk);
    ordy[i] = 1'b0;
    chk("idle_after_take", i, longint'(rdy_a[i]), 1);
  endtask

  task automatic op_check(input int i, input longint ops[21], input int lat_exp,
                          input longint d_exp, input longint b_exp);
    int lat;
    start(i, ops);
    wait_done(i, -10, 0, lat);
    chk("latency", i, lat, lat_exp);
    chk("diff_lit", i, longint'(dif_a[i]), d_exp);
    chk("borrow_lit", i, longint'(brw_a[i]), b_exp);
    consume(i);
  endtask

  initial begin
    longint ops[21];
    int     lat;
    tot = 0; bad = 0; chk_on = 1'b0;
    arst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cke[i] = 1'b1; vld[i] = 1'b0; ordy[i] = 1'b0; in_v[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", i, longint'(rdy_a[i]), 1);
      chk("rst_valid", i, longint'(ov_a[i]), 0);
      chk("rst_diff", i, longint'(dif_a[i]), 0);
    end
    arst_n = 1'b1;
    @(negedge clk);

    foreach (ops[k]) ops[k] = 0;
    ops[0] = 100; ops[1] = 10; ops[2] = 20; ops[3] = 30;
    op_check(0, ops, 3, 40, 0);
    ops[0] = 5; ops[1] = 10; ops[2] = 0; ops[3] = 0;
    op_check(0, ops, 3, 251, 1);
    ops[0] = 0; ops[1] = 255; ops[2] = 255; ops[3] = 255;
    op_check(0, ops, 3, 3, 1);

    // N=2 with backpressure and a vector offered while the result is held
    ops[0] = 7; ops[1] = 7;
    start(1, ops);
    wait_done(1, -10, 0, lat);
    chk("latency", 1, lat, 1);
    chk("diff_lit", 1, longint'(dif_a[1]), 0);
    ops[0] = 9; ops[1] = 2;
    load(1, ops);
    vld[1] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 1, longint'(ov_a[1]), 1);
      chk("hold_ready", 1, longint'(rdy_a[1]), 0);
      chk("hold_diff", 1, longint'(dif_a[1]), 0);
    end
    ordy[1] = 1'b1;
    @(negedge clk);
    ordy[1] = 1'b0;
    chk("b2b_idle_ready", 1, longint'(rdy_a[1]), 1);
    chk("b2b_idle_valid", 1, longint'(ov_a[1]), 0);
    @(negedge clk);
    vld[1] = 1'b0;
    chk("b2b_accepted", 1, longint'(rdy_a[1]), 0);
    @(negedge clk);
    chk("b2b_valid", 1, longint'(ov_a[1]), 1);
    chk("b2b_diff", 1, longint'(dif_a[1]), 7);
    consume(1);

    // Default configuration, then a reset in the middle of a run
    ops[0] = (64'sd1 <<< 21) - 1;
    for (int k = 1; k < 21; k++) ops[k] = 1;
    op_check(2, ops, 20, 2097131, 0);
    start(2, ops);
    repeat (10) @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 2, longint'(rdy_a[2]), 1);
    chk("mid_rst_valid", 2, longint'(ov_a[2]), 0);
    chk("mid_rst_diff", 2, longint'(dif_a[2]), 0);
    chk("mid_rst_borrow", 2, longint'(brw_a[2]), 0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    ops[0] = 50;
    for (int k = 1; k < 21; k++) ops[k] = k;
    op_check(2, ops, 20, 2096992, 1);

    // Clock enable low mid-run, then handshakes attempted with cke low
    ops[0] = 200; ops[1] = 1; ops[2] = 2; ops[3] = 3;
    start(0, ops);
    wait_done(0, 1, 3, lat);
    chk("cke_latency", 0, lat, 6);
    chk("cke_diff", 0, longint'(dif_a[0]), 194);
    cke[0] = 1'b0; ordy[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("cke_out_hs_ignored", 0, longint'(ov_a[0]), 1);
    cke[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    chk("cke_out_hs_taken", 0, longint'(rdy_a[0]), 1);
    cke[0] = 1'b0; vld[0] = 1'b1;
    repeat (2) @(negedge clk);
    vld[0] = 1'b0; cke[0] = 1'b1;
    @(negedge clk);
    chk("cke_in_hs_ignored", 0, longint'(rdy_a[0]), 1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
